// File: rtl/pool_pkg.sv
// pool_pkg: shared definitions for the pooling accelerator.
//   - state_t      : controller FSM states
//   - REG_*        : slave register word indices
//   - DATA_W       : data word width (signed Q8.24)
//   - FRAC_BITS    : number of fraction bits in a Q8.24 word
//   - DIM_W        : used low bits of the W/H/C registers
package pool_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 24;
  localparam int DIM_W     = 16;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_SRC  = 3'd1;
  localparam logic [2:0] REG_DST  = 3'd2;
  localparam logic [2:0] REG_W    = 3'd3;
  localparam logic [2:0] REG_H    = 3'd4;
  localparam logic [2:0] REG_C    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pool_window_max.sv
// pool_window_max: running maximum over one 2x2 pooling window.
//   Optional feature macro: POOL_RELU_EN (clamps negative maxima to 0).
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   i_clear  in   first word of a window: discard the previous max
//   i_en     in   a read word is accepted this cycle; update the register
//   i_data   in   word being accepted
//   o_max    out  max including i_data (valid while i_en), ReLU applied
//                 when POOL_RELU_EN is defined
module pool_window_max
  import pool_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_max
);

  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] w_cur;

  // Combinational view of the max including the word being accepted, so the
  // controller can capture the finished window on the fourth read's edge.
  always_comb begin
    if (i_clear) begin
      w_cur = i_data;
    end else if ($signed(i_data) > $signed(r_max)) begin
      w_cur = i_data;
    end else begin
      w_cur = r_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max <= '0;
    end else if (i_en) begin
      r_max <= w_cur;
    end
  end

`ifdef POOL_RELU_EN
  assign o_max = w_cur[DATA_W-1] ? '0 : w_cur;
`else
  assign o_max = w_cur;
`endif

endmodule

// File: rtl/pool_controller.sv
// pool_controller: Avalon-MM 2x2 stride-2 max-pooling accelerator.
//   Reads channel-major/row-major Q8.24 feature maps from SDRAM, takes the
//   signed max of each 2x2 window (optional ReLU via POOL_RELU_EN), and
//   writes the pooled maps densely back to SDRAM.
//   Optional feature macro: POOL_RELU_EN.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   slave_*               register port: 0 ctrl/status, 1 src, 2 dst,
//                         3 W, 4 H, 5 C; zero-latency read mux
//   master_waitrequest    SDRAM stall
//   master_address        byte address (word index * 4)
//   master_read/_write    SDRAM requests (never both high)
//   master_readdata       captured in the cycle waitrequest is low
//   master_writedata      pooled result
module pool_controller
  import pool_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic              slave_waitrequest,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [31:0]       master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata
);

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
  localparam logic [DIM_W-1:0] DIM_TWO = DIM_W'(2);

  // configuration / status
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [DIM_W-1:0] r_w;
  logic [DIM_W-1:0] r_h;
  logic [DIM_W-1:0] r_c;
  logic             r_done;
  logic             r_busy;

  // walk state
  state_t           r_state;
  logic [31:0]      r_wh;
  logic [31:0]      r_p;
  logic [31:0]      r_row_start;
  logic [31:0]      r_ch_start;
  logic [31:0]      r_q;
  logic [DIM_W-1:0] r_col;
  logic [DIM_W-1:0] r_row;
  logic [DIM_W-1:0] r_ch;
  logic [1:0]       r_k;

  // registered master outputs
  logic              r_master_read;
  logic              r_master_write;
  logic [31:0]       r_master_address;
  logic [DATA_W-1:0] r_master_writedata;

  logic              w_start;
  logic              w_cfg_wr;
  logic [31:0]       w_w32;
  logic [31:0]       w_h32;
  logic [31:0]       w_wh;
  logic [DIM_W-1:0]  w_ow;
  logic [DIM_W-1:0]  w_oh;
  logic              w_degenerate;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_last_ch;
  logic [31:0]       w_next_off;
  logic [31:0]       w_next_p;
  logic              w_rd_accept;
  logic [DATA_W-1:0] w_max;

  assign slave_waitrequest = 1'b0;
  assign master_read       = r_master_read;
  assign master_write      = r_master_write;
  assign master_address    = r_master_address;
  assign master_writedata  = r_master_writedata;

  assign w_start  = slave_write && (slave_address == REG_CTRL);
  assign w_cfg_wr = slave_write && !r_busy;

  assign w_w32 = {{(32-DIM_W){1'b0}}, r_w};
  assign w_h32 = {{(32-DIM_W){1'b0}}, r_h};
  assign w_wh  = w_w32 * w_h32;   // truncated to 32 bits

  // Odd dimensions floor: the last column/row simply never gets a window.
  assign w_ow = r_w >> 1;
  assign w_oh = r_h >> 1;

  assign w_degenerate = (r_w < DIM_TWO) || (r_h < DIM_TWO) || (r_c == '0);
  assign w_last_col   = (r_col == w_ow - DIM_ONE);
  assign w_last_row   = (r_row == w_oh - DIM_ONE);
  assign w_last_ch    = (r_ch  == r_c  - DIM_ONE);

  // Offset of the window word after the one currently being read
  // (read order p, p+1, p+W, p+W+1).
  always_comb begin
    case (r_k)
      2'd0:    w_next_off = 32'd1;
      2'd1:    w_next_off = w_w32;
      2'd2:    w_next_off = w_w32 + 32'd1;
      default: w_next_off = 32'd0;
    endcase
  end

  // Base of the next window after the current output is written.
  always_comb begin
    if (!w_last_col) begin
      w_next_p = r_p + 32'd2;
    end else if (!w_last_row) begin
      w_next_p = r_row_start + (w_w32 << 1);
    end else begin
      w_next_p = r_ch_start + r_wh;
    end
  end

  assign w_rd_accept = (r_state == ST_RD) && !master_waitrequest;

  pool_window_max u_window_max (
    .clk     (clk),
    .rst_n   (reset),
    .i_clear (r_k == 2'd0),
    .i_en    (w_rd_accept),
    .i_data  (master_readdata),
    .o_max   (w_max)
  );

  // Configuration registers; frozen while a job is running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src <= '0;
      r_dst <= '0;
      r_w   <= '0;
      r_h   <= '0;
      r_c   <= '0;
    end else if (w_cfg_wr) begin
      case (slave_address)
        REG_SRC: r_src <= slave_writedata;
        REG_DST: r_dst <= slave_writedata;
        REG_W:   r_w   <= slave_writedata[DIM_W-1:0];
        REG_H:   r_h   <= slave_writedata[DIM_W-1:0];
        REG_C:   r_c   <= slave_writedata[DIM_W-1:0];
        default: ;
      endcase
    end
  end

  // Zero-latency register read mux.
  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        REG_CTRL: slave_readdata = {30'b0, r_busy, r_done};
        REG_SRC:  slave_readdata = r_src;
        REG_DST:  slave_readdata = r_dst;
        REG_W:    slave_readdata = {{(32-DIM_W){1'b0}}, r_w};
        REG_H:    slave_readdata = {{(32-DIM_W){1'b0}}, r_h};
        REG_C:    slave_readdata = {{(32-DIM_W){1'b0}}, r_c};
        default:  slave_readdata = '0;
      endcase
    end
  end

  // Main FSM. done/busy are updated on the edge that enters DONE so that
  // software sees completion in the DONE cycle itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state            <= ST_IDLE;
      r_done             <= 1'b0;
      r_busy             <= 1'b0;
      r_wh               <= '0;
      r_p                <= '0;
      r_row_start        <= '0;
      r_ch_start         <= '0;
      r_q                <= '0;
      r_col              <= '0;
      r_row              <= '0;
      r_ch               <= '0;
      r_k                <= '0;
      r_master_read      <= 1'b0;
      r_master_write     <= 1'b0;
      r_master_address   <= '0;
      r_master_writedata <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_LOAD: begin
          r_wh        <= w_wh;
          r_p         <= r_src;
          r_row_start <= r_src;
          r_ch_start  <= r_src;
          r_q         <= r_dst;
          r_col       <= '0;
          r_row       <= '0;
          r_ch        <= '0;
          r_k         <= '0;
          if (w_degenerate) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state          <= ST_RD;
            r_master_read    <= 1'b1;
            r_master_address <= r_src << 2;
          end
        end

        ST_RD: begin
          if (!master_waitrequest) begin
            if (r_k == 2'd3) begin
              r_master_read      <= 1'b0;
              r_master_write     <= 1'b1;
              r_master_address   <= r_q << 2;
              r_master_writedata <= w_max;
              r_state            <= ST_WR;
            end else begin
              r_k              <= r_k + 2'd1;
              r_master_address <= (r_p + w_next_off) << 2;
            end
          end
        end

        ST_WR: begin
          if (!master_waitrequest) begin
            r_master_write <= 1'b0;
            r_q            <= r_q + 32'd1;
            r_k            <= '0;
            if (w_last_col && w_last_row && w_last_ch) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_p <= w_next_p;
              if (!w_last_col) begin
                r_col <= r_col + DIM_ONE;
              end else if (!w_last_row) begin
                r_col       <= '0;
                r_row       <= r_row + DIM_ONE;
                r_row_start <= w_next_p;
              end else begin
                r_col       <= '0;
                r_row       <= '0;
                r_ch        <= r_ch + DIM_ONE;
                r_row_start <= w_next_p;
                r_ch_start  <= w_next_p;
              end
              r_master_read    <= 1'b1;
              r_master_address <= w_next_p << 2;
              r_state          <= ST_RD;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_controller.sv
`timescale 1ns/1ps
module tb_pool_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        slave_waitrequest;
  logic [2:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_write;
  logic [31:0] master_writedata;

  always #5 clk = ~clk;

  pool_controller dut (
    .clk                (clk),
    .reset              (reset),
    .slave_waitrequest  (slave_waitrequest),
    .slave_address      (slave_address),
    .slave_read         (slave_read),
    .slave_readdata     (slave_readdata),
    .slave_write        (slave_write),
    .slave_writedata    (slave_writedata),
    .master_waitrequest (master_waitrequest),
    .master_address     (master_address),
    .master_read        (master_read),
    .master_readdata    (master_readdata),
    .master_write       (master_write),
    .master_writedata   (master_writedata)
  );

  // SDRAM model
  logic [31:0] mem [0:1023];
  assign master_readdata = mem[master_address[11:2]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // bus monitor state
  bit          stall_en = 0;
  bit          odd_mode = 0;
  int          odd_src = 0;
  int          odd_w = 1;
  int          stall_cnt, rd_cnt, rd_cyc, both_err, stab_err, bad_cnt;
  int          rel;
  bit          pend = 0;
  logic [31:0] pend_addr, pend_data;
  logic        pend_rd, pend_wr;
  int unsigned wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int unsigned exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  always @(negedge clk)
    master_waitrequest = (stall_en && reset) ? ($urandom_range(0, 2) == 0) : 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      pend = 0;
    end else begin
      if (master_read && master_write) both_err++;
      if (pend && (master_address !== pend_addr || master_writedata !== pend_data ||
                   master_read !== pend_rd || master_write !== pend_wr))
        stab_err++;
      pend      = (master_read || master_write) && master_waitrequest;
      pend_addr = master_address;
      pend_data = master_writedata;
      pend_rd   = master_read;
      pend_wr   = master_write;
      if (pend) stall_cnt++;
      if (master_read) rd_cyc++;
      if (master_read && !master_waitrequest) begin
        rd_cnt++;
        if (odd_mode) begin
          rel = int'(master_address >> 2) - odd_src;
          if (rel < 0 || (rel % odd_w) >= 4 || (rel / odd_w) >= 2) bad_cnt++;
        end
      end
      if (master_write && !master_waitrequest) begin
        mem[master_address[11:2]] = master_writedata;
        wr_addr_q.push_back(master_address >> 2);
        wr_data_q.push_back(master_writedata);
      end
    end
  end

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_read = 0; slave_write = 1; slave_address = a; slave_writedata = d;
    @(negedge clk);
    slave_write = 0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_write = 0; slave_read = 1; slave_address = a;
    #1 d = slave_readdata;
    slave_read = 0;
  endtask

  // Reference: pooled outputs straight from the layout rules.
  task automatic build_expected(input int src, input int dst, input int w, input int h, input int c);
    int b, m, v;
    exp_addr_q.delete();
    exp_data_q.delete();
    if (w < 2 || h < 2 || c == 0) return;
    for (int ch = 0; ch < c; ch++)
      for (int r = 0; r < h / 2; r++)
        for (int col = 0; col < w / 2; col++) begin
          b = src + ch * w * h + 2 * r * w + 2 * col;
          m = int'(mem[b]);
          v = int'(mem[b + 1]);     if (v > m) m = v;
          v = int'(mem[b + w]);     if (v > m) m = v;
          v = int'(mem[b + w + 1]); if (v > m) m = v;
`ifdef POOL_RELU_EN
          if (m < 0) m = 0;
`endif
          exp_addr_q.push_back(dst + ch * (w / 2) * (h / 2) + r * (w / 2) + col);
          exp_data_q.push_back(m);
        end
  endtask

  task automatic run_job(input int src, input int dst, input int w, input int h, input int c,
                         input int abort_cyc, input bit busy_wr, output int cyc);
    wr_reg(1, src); wr_reg(2, dst); wr_reg(3, w); wr_reg(4, h); wr_reg(5, c);
    build_expected(src, dst, w, h, c);
    wr_addr_q.delete(); wr_data_q.delete();
    stall_cnt = 0; rd_cnt = 0; rd_cyc = 0; both_err = 0; stab_err = 0; bad_cnt = 0;
    @(negedge clk);
    slave_write = 1; slave_read = 1; slave_address = 0; slave_writedata = 1;
    @(posedge clk);
    #1;
    slave_write = 0;
    #1;
    cyc = 1;
    check_eq("start_status", slave_readdata, 32'h2);
    while (slave_readdata[0] !== 1'b1 && cyc < 5000) begin
      if (busy_wr && cyc == 4) begin
        slave_read = 0; slave_write = 1; slave_address = 3; slave_writedata = 9;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (busy_wr && cyc == 5) begin
        slave_write = 0; slave_read = 1; slave_address = 0;
        #1;
      end
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        reset = 0;
        return;
      end
    end
    check_eq("done_in_time", cyc < 5000, 1);
    slave_read = 0;
    $display("job src=%0d dst=%0d W=%0d H=%0d C=%0d outputs=%0d writes=%0d stalls=%0d done_cycle=%0d",
             src, dst, w, h, c, exp_addr_q.size(), wr_addr_q.size(), stall_cnt, cyc);
  endtask

  function automatic int exp_done_cycle();
    return (exp_addr_q.size() == 0) ? 2 : 2 + 5 * exp_addr_q.size() + stall_cnt;
  endfunction

  task automatic verify(input string tag);
    int n;
    check_eq({tag, "_nwrites"}, wr_addr_q.size(), exp_addr_q.size());
    n = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_addr"}, wr_addr_q[i], exp_addr_q[i]);
      check_eq({tag, "_data"}, wr_data_q[i], exp_data_q[i]);
    end
    check_eq({tag, "_rd_wr_overlap"}, both_err, 0);
    check_eq({tag, "_stall_stable"}, stab_err, 0);
  endtask

  task automatic fill_basic();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem[1 + i] = i * 32'h0040_0000;
  endtask

  task automatic check_basic_consts(input string tag);
    check_eq({tag, "_o0"}, mem[256], 32'h0140_0000);
    check_eq({tag, "_o1"}, mem[257], 32'h01C0_0000);
    check_eq({tag, "_o2"}, mem[258], 32'h0340_0000);
    check_eq({tag, "_o3"}, mem[259], 32'h03C0_0000);
  endtask

  initial begin
    int cyc;
    int w, h, c;
    logic [31:0] rd;
    logic [31:0] neg_exp;
`ifdef POOL_RELU_EN
    neg_exp = 32'h0000_0000;
`else
    neg_exp = 32'hFF00_0000;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    slave_read = 1; slave_address = 0;
    #1;
    check_eq("rst_status", slave_readdata, 0);
    check_eq("rst_mread", master_read, 0);
    check_eq("rst_mwrite", master_write, 0);
    check_eq("rst_maddr", master_address, 0);
    check_eq("rst_mwdata", master_writedata, 0);
    slave_read = 0;
    @(negedge clk);
    reset = 1;
    rd_reg(3, rd);
    check_eq("rst_reg_w", rd, 0);

    // basic pooling
    fill_basic();
    run_job(1, 256, 4, 4, 1, 0, 0, cyc);
    check_eq("basic_done_cycle", cyc, 22);
    verify("basic");
    check_basic_consts("basic");
    rd_reg(3, rd);
    check_eq("reg_w_readback", rd, 4);
    rd_reg(2, rd);
    check_eq("reg_dst_readback", rd, 256);
    rd_reg(0, rd);
    check_eq("status_done", rd, 1);

    // config write while busy must be ignored
    fill_basic();
    run_job(1, 256, 4, 4, 1, 0, 1, cyc);
    check_eq("busywr_done_cycle", cyc, 22);
    verify("busywr");
    rd_reg(3, rd);
    check_eq("busywr_reg_w", rd, 4);

    // negative inputs
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 10; i < 18; i++) mem[i] = 32'hFF00_0000;
    run_job(10, 300, 2, 2, 2, 0, 0, cyc);
    check_eq("neg_done_cycle", cyc, 12);
    verify("neg");
    check_eq("neg_o0", mem[300], neg_exp);
    check_eq("neg_o1", mem[301], neg_exp);

    // odd dimensions
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 20; i < 35; i++) mem[i] = $urandom;
    odd_mode = 1; odd_src = 20; odd_w = 5;
    run_job(20, 320, 5, 3, 1, 0, 0, cyc);
    odd_mode = 0;
    check_eq("odd_done_cycle", cyc, 12);
    check_eq("odd_nwrites_const", wr_addr_q.size(), 2);
    check_eq("odd_bad_addr", bad_cnt, 0);
    check_eq("odd_reads", rd_cnt, 8);
    verify("odd");

    // stalls on the basic case
    fill_basic();
    stall_en = 1;
    run_job(1, 256, 4, 4, 1, 0, 0, cyc);
    stall_en = 0;
    check_eq("stall_done_cycle", cyc, 22 + stall_cnt);
    check_eq("stall_seen", stall_cnt > 0, 1);
    verify("stall");
    check_basic_consts("stall");

    // degenerate configurations
    run_job(1, 256, 1, 4, 1, 0, 0, cyc);
    check_eq("degen_w_cycle", cyc, 2);
    check_eq("degen_w_noread", rd_cyc, 0);
    check_eq("degen_w_nowrite", wr_addr_q.size(), 0);
    run_job(1, 256, 4, 1, 1, 0, 0, cyc);
    check_eq("degen_h_cycle", cyc, 2);
    check_eq("degen_h_noread", rd_cyc, 0);
    run_job(1, 256, 4, 4, 0, 0, 0, cyc);
    check_eq("degen_c_cycle", cyc, 2);
    check_eq("degen_c_noread", rd_cyc, 0);

    // reset mid-run, then restart
    fill_basic();
    run_job(1, 256, 4, 4, 1, 10, 0, cyc);
    #1;
    check_eq("midrst_mread", master_read, 0);
    slave_read = 1; slave_address = 0;
    #1;
    check_eq("midrst_status", slave_readdata, 0);
    @(posedge clk);
    #1;
    check_eq("midrst_mread_held", master_read, 0);
    check_eq("midrst_mwrite_held", master_write, 0);
    slave_read = 0;
    @(negedge clk);
    reset = 1;
    fill_basic();
    run_job(1, 256, 4, 4, 1, 0, 0, cyc);
    check_eq("restart_done_cycle", cyc, 22);
    verify("restart");
    check_basic_consts("restart");

    // randomized configurations
    for (int t = 0; t < 6; t++) begin
      w = $urandom_range(2, 7);
      h = $urandom_range(2, 7);
      c = $urandom_range(1, 3);
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      for (int i = 400; i < 400 + w * h * c; i++) mem[i] = $urandom;
      stall_en = $urandom_range(0, 1);
      run_job(400, 700, w, h, c, 0, 0, cyc);
      stall_en = 0;
      check_eq("rand_done_cycle", cyc, exp_done_cycle());
      verify("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
